// File: rtl/top_pkg.sv
// ============================================================================
// top_pkg : shared types and write addresses for the RSA round-trip engine
// Revision: 1.0
// ============================================================================
`default_nettype none

package top_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ENC  = 3'd1,
        WR_C = 3'd2,
        DEC  = 3'd3,
        WR_P = 3'd4,
        DONE = 3'd5
    } state_t;

    typedef enum logic {
        OP_SQ  = 1'b0,
        OP_MUL = 1'b1
    } op_t;

    localparam logic [31:0] ADDR_C = 32'h0000_0064;
    localparam logic [31:0] ADDR_P = 32'h0000_0068;

endpackage

`default_nettype wire

// File: rtl/top_modmul.sv
// ============================================================================
// modmul : interleaved shift-add modular multiplier, r = a*b mod n, MSB first
// Revision: 1.0
// ============================================================================
`default_nettype none

module modmul
    import top_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         go,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] n,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] r
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  n_q;
    logic [W+1:0]  acc;
    logic [IW-1:0] cnt;

    logic          bit_b;
    logic [W+1:0]  addend;
    logic [W+1:0]  nn;
    logic [W+1:0]  prev;
    logic [W+1:0]  sum;
    logic [W+1:0]  s1;
    logic [W+1:0]  s2;

    // The go cycle already consumes the top multiplier bit from the live inputs,
    // so the result lands exactly W cycles after the pulse.
    assign bit_b  = go ? b[W-1] : b_q[cnt];
    assign addend = {2'b00, (go ? a : a_q)};
    assign nn     = {2'b00, (go ? n : n_q)};
    assign prev   = go ? '0 : acc;
    assign sum    = (prev << 1) + (bit_b ? addend : '0);
    assign s1     = (sum >= nn) ? (sum - nn) : sum;
    assign s2     = (s1 >= nn) ? (s1 - nn) : s1;
    assign r      = acc[W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q  <= '0;
            b_q  <= '0;
            n_q  <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (go) begin
                a_q  <= a;
                b_q  <= b;
                n_q  <= n;
                acc  <= s2;
                cnt  <= IW'(W - 2);
                busy <= 1'b1;
            end else if (busy) begin
                acc <= s2;
                if (cnt == '0) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/top.sv
// ============================================================================
// top : RSA encrypt-then-decrypt sequencer writing C and P to a memory port
// Revision: 1.0
// ============================================================================
`default_nettype none

module top
    import top_pkg::*;
#(
    parameter int W      = 16,
    parameter int MOD    = 33,
    parameter int PUB_E  = 3,
    parameter int PRIV_D = 7,
    parameter int MSG    = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        MemWrite,
    output logic [31:0] DataAdr,
    output logic [31:0] WriteData,
    output logic        busy,
    output logic        done
);

    localparam int            IW      = (W > 1) ? $clog2(W) : 1;
    localparam logic [W-1:0]  C_ONE   = W'((MOD == 1) ? 0 : 1);
    localparam logic [W-1:0]  C_MOD   = W'(MOD);
    localparam logic [W-1:0]  C_MSG   = W'(MSG);
    localparam logic [W-1:0]  C_PUB   = W'(PUB_E);
    localparam logic [W-1:0]  C_PRIV  = W'(PRIV_D);

    state_t        state;
    op_t           op;
    logic [W-1:0]  acc;
    logic [W-1:0]  base;
    logic [W-1:0]  expo;
    logic [IW-1:0] idx;
    logic          mm_go;
    logic          start_q;

    logic          start_rise;
    logic          exp_bit;
    logic          mm_busy;
    logic          mm_done;
    logic [W-1:0]  mm_b;
    logic [W-1:0]  mm_r;

    assign start_rise = start & ~start_q;
    assign exp_bit    = expo[idx];
    assign mm_b       = (op == OP_MUL) ? base : acc;

    modmul #(.W(W)) u_modmul (
        .clk   (clk),
        .reset (reset),
        .go    (mm_go),
        .a     (acc),
        .b     (mm_b),
        .n     (C_MOD),
        .busy  (mm_busy),
        .done  (mm_done),
        .r     (mm_r)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            op        <= OP_SQ;
            acc       <= '0;
            base      <= '0;
            expo      <= '0;
            idx       <= '0;
            mm_go     <= 1'b0;
            start_q   <= 1'b0;
            MemWrite  <= 1'b0;
            DataAdr   <= '0;
            WriteData <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            start_q  <= start;
            mm_go    <= 1'b0;
            MemWrite <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start_rise) begin
                        state <= ENC;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        acc   <= C_ONE;
                        base  <= C_MSG;
                        expo  <= C_PUB;
                        idx   <= IW'(W - 1);
                        op    <= OP_SQ;
                        mm_go <= 1'b1;
                    end
                end
                ENC, DEC: begin
                    if (mm_done && !mm_busy) begin
                        acc <= mm_r;
                        // A set exponent bit follows its square with a multiply by the base.
                        if (op == OP_SQ && exp_bit) begin
                            op    <= OP_MUL;
                            mm_go <= 1'b1;
                        end else if (idx != '0) begin
                            idx   <= idx - 1'b1;
                            op    <= OP_SQ;
                            mm_go <= 1'b1;
                        end else begin
                            MemWrite  <= 1'b1;
                            WriteData <= 32'(mm_r);
                            if (state == ENC) begin
                                DataAdr <= ADDR_C;
                                state   <= WR_C;
                            end else begin
                                DataAdr <= ADDR_P;
                                state   <= WR_P;
                            end
                        end
                    end
                end
                WR_C: begin
                    state <= DEC;
                    base  <= acc;
                    acc   <= C_ONE;
                    expo  <= C_PRIV;
                    idx   <= IW'(W - 1);
                    op    <= OP_SQ;
                    mm_go <= 1'b1;
                end
                WR_P: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_top.sv
// ============================================================================
// tb_top : directed bench running four parameterisations of top side by side
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_top;

    localparam int N = 4;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic        clr   = 1'b0;

    logic        mw  [N];
    logic [31:0] adr [N];
    logic [31:0] dat [N];
    logic        bsy [N];
    logic        dn  [N];

    int          wcnt [N];
    logic [31:0] wadr [N][4];
    logic [31:0] wdat [N][4];

    int          vectors     = 0;
    int          miscompares = 0;
    int          elapsed     = 0;
    int          lat     [N];
    int          lat_ref [N];

    logic [31:0] exp_c [N] = '{32'd26, 32'd2790, 32'd0, 32'd1};
    logic [31:0] exp_p [N] = '{32'd5,  32'd65,   32'd0, 32'd1};

    top #(.W(16), .MOD(33),   .PUB_E(3),  .PRIV_D(7),    .MSG(5))  u0 (
        .clk(clk), .reset(rst), .start(start), .MemWrite(mw[0]),
        .DataAdr(adr[0]), .WriteData(dat[0]), .busy(bsy[0]), .done(dn[0]));
    top #(.W(16), .MOD(3233), .PUB_E(17), .PRIV_D(2753), .MSG(65)) u1 (
        .clk(clk), .reset(rst), .start(start), .MemWrite(mw[1]),
        .DataAdr(adr[1]), .WriteData(dat[1]), .busy(bsy[1]), .done(dn[1]));
    top #(.W(16), .MOD(33),   .PUB_E(3),  .PRIV_D(7),    .MSG(0))  u2 (
        .clk(clk), .reset(rst), .start(start), .MemWrite(mw[2]),
        .DataAdr(adr[2]), .WriteData(dat[2]), .busy(bsy[2]), .done(dn[2]));
    top #(.W(16), .MOD(33),   .PUB_E(3),  .PRIV_D(7),    .MSG(1))  u3 (
        .clk(clk), .reset(rst), .start(start), .MemWrite(mw[3]),
        .DataAdr(adr[3]), .WriteData(dat[3]), .busy(bsy[3]), .done(dn[3]));

    // Rising edges at 7, 17, 27 ... keep the 22 ns / 25 ns stimulus off the edges.
    initial begin
        #2;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (clr) begin
                wcnt[k] <= 0;
            end else if (mw[k]) begin
                if (wcnt[k] < 4) begin
                    wadr[k][wcnt[k]] <= adr[k];
                    wdat[k][wcnt[k]] <= dat[k];
                end
                wcnt[k] <= wcnt[k] + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, expv, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        elapsed++;
        for (int k = 0; k < N; k++)
            if (dn[k] && lat[k] == 0) lat[k] = elapsed;
    endtask

    task automatic arm_counters();
        elapsed = 0;
        for (int k = 0; k < N; k++) lat[k] = 0;
    endtask

    task automatic launch();
        @(posedge clk);
        #1 clr = 1'b1;
        #7 clr = 1'b0;
        start = 1'b1;
        arm_counters();
    endtask

    task automatic wait_all(input string tag);
        bit all_done;
        all_done = 1'b0;
        for (int i = 0; i < 3000 && !all_done; i++) begin
            tick();
            all_done = 1'b1;
            for (int k = 0; k < N; k++)
                if (lat[k] == 0) all_done = 1'b0;
        end
        chk({tag, " completion"}, 32'(all_done), 32'd1);
    endtask

    task automatic check_run(input string tag);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s u%0d write count", tag, k), 32'(wcnt[k]), 32'd2);
            chk($sformatf("%s u%0d C addr", tag, k), wadr[k][0], 32'h64);
            chk($sformatf("%s u%0d C data", tag, k), wdat[k][0], exp_c[k]);
            chk($sformatf("%s u%0d P addr", tag, k), wadr[k][1], 32'h68);
            chk($sformatf("%s u%0d P data", tag, k), wdat[k][1], exp_p[k]);
            chk($sformatf("%s u%0d busy", tag, k), 32'(bsy[k]), 32'd0);
            chk($sformatf("%s u%0d done", tag, k), 32'(dn[k]), 32'd1);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " MemWrite"},  32'(mw[0]),  32'd0);
        chk({tag, " DataAdr"},   adr[0],      32'd0);
        chk({tag, " WriteData"}, dat[0],      32'd0);
        chk({tag, " busy"},      32'(bsy[0]), 32'd0);
        chk({tag, " done"},      32'(dn[0]),  32'd0);
    endtask

    initial begin
        // Run 1: reset to 22 ns, start raised at 25 ns and held.
        @(posedge clk);
        #1;
        check_zero("reset");
        @(posedge clk);
        #1 clr = 1'b1;
        #4 rst = 1'b0;
        #3 clr = 1'b0;
        start = 1'b1;
        arm_counters();
        tick();
        tick();
        chk("run1 busy after start", 32'(bsy[0]), 32'd1);
        chk("run1 done after start", 32'(dn[0]),  32'd0);
        wait_all("run1");
        tick();
        check_run("run1");
        for (int k = 0; k < N; k++) lat_ref[k] = lat[k];
        chk("latency MSG=0 vs MSG=5", 32'(lat[2]), 32'(lat[0]));
        chk("latency MSG=1 vs MSG=5", 32'(lat[3]), 32'(lat[0]));

        // Run 2: done holds with start low; start toggles mid-run are ignored.
        start = 1'b0;
        tick();
        tick();
        chk("done held while idle", 32'(dn[0]), 32'd1);
        launch();
        repeat (3) tick();
        chk("run2 busy", 32'(bsy[0]), 32'd1);
        chk("run2 done cleared", 32'(dn[0]), 32'd0);
        repeat (40) tick();
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        repeat (100) tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        wait_all("run2");
        tick();
        check_run("run2");
        for (int k = 0; k < N; k++)
            chk($sformatf("run2 u%0d latency", k), 32'(lat[k]), 32'(lat_ref[k]));

        // Run 3: reset pulsed during encryption aborts with no writes.
        start = 1'b0;
        tick();
        launch();
        repeat (60) tick();
        chk("run3 busy mid-ENC", 32'(bsy[0]), 32'd1);
        #2 rst = 1'b1;
        start = 1'b0;
        #1;
        check_zero("mid-run reset");
        chk("mid-run reset u1 DataAdr", adr[1], 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (800) tick();
        for (int k = 0; k < N; k++) begin
            chk($sformatf("after abort u%0d writes", k), 32'(wcnt[k]), 32'd0);
            chk($sformatf("after abort u%0d busy", k), 32'(bsy[k]), 32'd0);
        end

        // Run 4: a fresh start edge gives a complete, identical run.
        launch();
        wait_all("run4");
        tick();
        check_run("run4");
        for (int k = 0; k < N; k++)
            chk($sformatf("run4 u%0d latency", k), 32'(lat[k]), 32'(lat_ref[k]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter W, default 16: operand and datapath width in bits.
REQ-002 Parameter MOD, default 33: RSA modulus; MOD < 2^(W-1).
REQ-003 Parameter PUB_E, default 3: public exponent.
REQ-004 Parameter PRIV_D, default 7: private exponent.
REQ-005 Parameter MSG, default 5: plaintext; MSG < MOD.
REQ-006 clk  input  1: single clock; all state changes on the rising edge.
REQ-007 reset  input  1: asynchronous, active-high reset.
REQ-008 start  input  1: level input; a run begins on a 0->1 transition.
REQ-009 MemWrite  output  1: one-cycle write strobe.
REQ-010 DataAdr  output  32: write address, valid while MemWrite=1.
REQ-011 WriteData  output  32: write data, zero-extended result, valid while MemWrite=1.
REQ-012 busy  output  1: high while a run is in progress.
REQ-013 done  output  1: high after a run completes; held until the next accepted start or reset.

Function
REQ-014 start SHALL be registered each cycle; a rising edge is start=1 with the previous sample 0.
REQ-015 The previous-sample register SHALL reset to 0, so start held high through reset deassertion counts as one rising edge.
REQ-016 FSM states SHALL be IDLE, ENC, WR_C, DEC, WR_P, DONE.
REQ-017 IDLE/DONE + start rising edge -> ENC; this SHALL set busy=1 and done=0 on the next cycle.
REQ-018 ENC SHALL compute C = MSG^PUB_E mod MOD by left-to-right square-and-multiply over all W exponent bits, with no leading-zero skip.
REQ-019 The accumulator SHALL start at 1 mod MOD; every bit SHALL square it, and a 1-bit SHALL then multiply it by the base.
REQ-020 ENC done -> WR_C: MemWrite=1, DataAdr=0x64, WriteData=C for exactly one cycle -> DEC.
REQ-021 DEC SHALL compute P = C^PRIV_D mod MOD by the same algorithm.
REQ-022 DEC done -> WR_P: MemWrite=1, DataAdr=0x68, WriteData=P for one cycle -> DONE with busy=0, done=1.
REQ-023 Start edges while busy=1 SHALL be ignored.
REQ-024 Modular multiply SHALL use interleaved shift-add, MSB first, one bit per cycle: R=2R+(b_i?a:0), then at most two conditional subtractions of MOD.
REQ-025 Internal width SHALL be W+2 bits; one multiply SHALL take exactly W cycles after its start pulse.
REQ-026 Outside WR_C/WR_P: MemWrite=0; DataAdr and WriteData SHALL hold their last values.
REQ-027 Run latency SHALL be deterministic, with cycle count a function of W and the exponent bit patterns only.

Reset
REQ-028 Reset SHALL force IDLE, MemWrite=0, DataAdr=0, WriteData=0, busy=0, done=0, all datapath registers 0, and the start sample to 0.
REQ-029 Reset mid-run SHALL abort with no further writes; a new run requires a fresh start edge after reset release.

Structure
REQ-030 Package top_pkg SHALL hold the state enum and the address constants ADDR_C=0x64 and ADDR_P=0x68.
REQ-031 Sub-module modmul: ports clk, reset, go, a, b, n, busy, done, r; used for all squares and multiplies.
REQ-032 The exponentiation sequencer and write logic SHALL live in top.

Verification
REQ-033 Defaults; reset 22 ns; start 0 then 1 at 25 ns and held; 10 ns clock -> write 26 @0x64, then 5 @0x68, done=1, exactly two MemWrite pulses.
REQ-034 MOD=3233, PUB_E=17, PRIV_D=2753, MSG=65 -> 2790 @0x64, 65 @0x68.
REQ-035 MSG=0 -> 0 @0x64, 0 @0x68; MSG=1 -> 1 @0x64, 1 @0x68.
REQ-036 Reset pulsed mid-ENC -> outputs zero immediately, no MemWrite; new start edge -> full correct run.
REQ-037 Start toggled during a run -> ignored; toggled after done -> second identical run with identical latency.
